// File: rtl/pwr_domain_ctrl_if.sv
// Power-state request channel between the APB register bank and pwr_domain_ctrl.
interface pwr_domain_ctrl_if;
   logic       i_req_valid;
   logic [1:0] i_state_req;
   logic       o_req_ready;

   modport master (output i_req_valid, output i_state_req, input  o_req_ready);
   modport slave  (input  i_req_valid, input  i_state_req, output o_req_ready);
endinterface

// File: rtl/pwr_domain_ctrl.sv
// Multi-domain power controller: sequences ACTIVE/IDLE/SLEEP/OFF across gated clock
// domains with enable/ack handshake, auto-idle, maskable wake-up and ack-timeout.
module pwr_domain_ctrl #(
   parameter int unsigned      N_DOM      = 3,
   parameter int unsigned      N_WAKE     = 4,
   parameter int unsigned      CNT_W      = 16,
   parameter logic [N_DOM-1:0] IDLE_MASK  = N_DOM'(1),
   parameter logic [N_DOM-1:0] SLEEP_MASK = '0,
   parameter int unsigned      ACK_TO     = 64
) (
   input  logic              i_sys_clk,
   input  logic              i_rst_n,
   pwr_domain_ctrl_if.slave  req_if,
   input  logic              i_auto_idle_en,
   input  logic [CNT_W-1:0]  i_idle_timeout,
   input  logic              i_activity,
   input  logic [N_WAKE-1:0] i_wake_src,
   input  logic [N_WAKE-1:0] i_wake_mask,
   input  logic [N_DOM-1:0]  i_clk_ack,
   output logic [N_DOM-1:0]  o_clk_en,
   output logic [1:0]        o_state,
   output logic              o_busy,
   output logic              o_wake_event,
   output logic [N_WAKE-1:0] o_wake_cause,
   output logic              o_ack_err
);

   localparam int unsigned ACK_W = (ACK_TO > 2) ? $clog2(ACK_TO) : 1;

   typedef enum logic [1:0] {
      PS_ACTIVE = 2'b00,
      PS_IDLE   = 2'b01,
      PS_SLEEP  = 2'b10,
      PS_OFF    = 2'b11
   } pstate_t;

   typedef enum logic {
      FSM_STABLE = 1'b0,
      FSM_TRANS  = 1'b1
   } fsm_t;

   fsm_t              r_fsm;
   pstate_t           r_state;
   pstate_t           r_target;
   logic [N_DOM-1:0]  r_clk_en;
   logic [N_WAKE-1:0] r_wake_cause;
   logic              r_wake_event;
   logic              r_ack_err;
   logic              r_pending;
   logic              r_wake_trans;
   logic [CNT_W-1:0]  r_idle_cnt;
   logic [CNT_W-1:0]  r_timeout_q;
   logic [ACK_W-1:0]  r_ack_cnt;

   logic [N_WAKE-1:0] w_masked_wake;
   logic              w_stable;
   logic              w_wake;
   logic              w_wake_in_trans;
   logic              w_req_acc;
   logic              w_auto;
   logic              w_ack_match;
   logic              w_ack_to;
   logic              w_idle_clr;
   pstate_t           w_req_state;

   function automatic logic [N_DOM-1:0] f_target_mask(input pstate_t s);
      case (s)
         PS_ACTIVE: return '1;
         PS_IDLE:   return IDLE_MASK;
         PS_SLEEP:  return SLEEP_MASK;
         default:   return '0;
      endcase
   endfunction

   assign w_masked_wake   = i_wake_src & i_wake_mask;
   assign w_stable        = (r_fsm == FSM_STABLE);
   assign w_req_state     = pstate_t'(req_if.i_state_req);
   assign w_wake          = w_stable && (r_state != PS_ACTIVE) &&
                            ((|w_masked_wake) || (i_activity && (r_state == PS_IDLE)));
   // Wakes seen while heading into a low-power state are deferred until commit
   assign w_wake_in_trans = (r_target != PS_ACTIVE) && (|w_masked_wake);
   assign w_req_acc       = req_if.i_req_valid && req_if.o_req_ready && (w_req_state != r_state);
   assign w_auto          = w_stable && (r_state == PS_ACTIVE) && i_auto_idle_en &&
                            (i_idle_timeout != '0) && (r_idle_cnt == i_idle_timeout) &&
                            !req_if.i_req_valid;
   assign w_ack_match     = (i_clk_ack == r_clk_en);
   assign w_ack_to        = (r_ack_cnt == ACK_W'(ACK_TO - 1));
   assign w_idle_clr      = !(w_stable && (r_state == PS_ACTIVE)) || i_activity ||
                            (i_idle_timeout != r_timeout_q);

   assign req_if.o_req_ready = w_stable && !r_pending && !w_wake;

   assign o_clk_en     = r_clk_en;
   assign o_state      = r_state;
   assign o_busy       = (r_fsm == FSM_TRANS);
   assign o_wake_event = r_wake_event;
   assign o_wake_cause = r_wake_cause;
   assign o_ack_err    = r_ack_err;

   always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_fsm        <= FSM_STABLE;
         r_state      <= PS_ACTIVE;
         r_target     <= PS_ACTIVE;
         r_clk_en     <= '1;
         r_wake_cause <= '0;
         r_wake_event <= 1'b0;
         r_ack_err    <= 1'b0;
         r_pending    <= 1'b0;
         r_wake_trans <= 1'b0;
         r_idle_cnt   <= '0;
         r_timeout_q  <= '0;
         r_ack_cnt    <= '0;
      end else begin
         r_wake_event <= 1'b0;
         r_ack_err    <= 1'b0;
         r_timeout_q  <= i_idle_timeout;

         // Inactivity counter, saturating at the programmed timeout
         if (w_idle_clr) begin
            r_idle_cnt <= '0;
         end else if (r_idle_cnt < i_idle_timeout) begin
            r_idle_cnt <= r_idle_cnt + CNT_W'(1);
         end

         case (r_fsm)
            FSM_STABLE: begin
               if (w_wake) begin
                  r_wake_cause <= w_masked_wake;
                  r_target     <= PS_ACTIVE;
                  r_clk_en     <= '1;
                  r_ack_cnt    <= '0;
                  r_wake_trans <= 1'b1;
                  r_fsm        <= FSM_TRANS;
               end else if (w_req_acc) begin
                  r_target     <= w_req_state;
                  r_clk_en     <= f_target_mask(w_req_state);
                  r_ack_cnt    <= '0;
                  r_wake_trans <= 1'b0;
                  r_fsm        <= FSM_TRANS;
               end else if (w_auto) begin
                  r_target     <= PS_IDLE;
                  r_clk_en     <= IDLE_MASK;
                  r_ack_cnt    <= '0;
                  r_wake_trans <= 1'b0;
                  r_fsm        <= FSM_TRANS;
               end
            end
            FSM_TRANS: begin
               if (w_ack_match || w_ack_to) begin
                  r_state   <= r_target;
                  r_ack_err <= !w_ack_match;
                  if (r_pending || w_wake_in_trans) begin
                     // Commit the low-power state, then head straight back to ACTIVE
                     if (!r_pending) begin
                        r_wake_cause <= w_masked_wake;
                     end
                     r_pending    <= 1'b0;
                     r_target     <= PS_ACTIVE;
                     r_clk_en     <= '1;
                     r_ack_cnt    <= '0;
                     r_wake_trans <= 1'b1;
                  end else begin
                     r_wake_event <= r_wake_trans;
                     r_wake_trans <= 1'b0;
                     r_fsm        <= FSM_STABLE;
                  end
               end else begin
                  r_ack_cnt <= r_ack_cnt + ACK_W'(1);
                  if (w_wake_in_trans && !r_pending) begin
                     r_pending    <= 1'b1;
                     r_wake_cause <= w_masked_wake;
                  end
               end
            end
            default: r_fsm <= FSM_STABLE;
         endcase
      end
   end

endmodule

// File: tb/tb_pwr_domain_ctrl.sv
// Directed bench for pwr_domain_ctrl; commits are checked against a scoreboard of
// expected {state, clk_en, wake_event, wake_cause, ack_err} snapshots.
module tb_pwr_domain_ctrl;

   logic       clk;
   logic       rst_n;
   logic       auto_en;
   logic [15:0] timeout;
   logic       activity;
   logic [3:0] wake_src;
   logic [3:0] wake_mask;
   logic [2:0] ack;
   logic       ack_stuck;
   logic [2:0] clk_en;
   logic [1:0] state;
   logic       busy;
   logic       wake_event;
   logic [3:0] wake_cause;
   logic       ack_err;

   int n_checks = 0;
   int n_err    = 0;
   int n_wake_ev = 0;
   int n_ack_err = 0;
   logic [1:0] prev_state = 2'b00;
   logic       prev_busy  = 1'b0;
   logic [10:0] sb[$];

   pwr_domain_ctrl_if req_if ();

   pwr_domain_ctrl dut (
      .i_sys_clk      (clk),
      .i_rst_n        (rst_n),
      .req_if         (req_if.slave),
      .i_auto_idle_en (auto_en),
      .i_idle_timeout (timeout),
      .i_activity     (activity),
      .i_wake_src     (wake_src),
      .i_wake_mask    (wake_mask),
      .i_clk_ack      (ack),
      .o_clk_en       (clk_en),
      .o_state        (state),
      .o_busy         (busy),
      .o_wake_event   (wake_event),
      .o_wake_cause   (wake_cause),
      .o_ack_err      (ack_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Clock-gate model: status follows the enable one cycle late, or sticks running
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) ack <= 3'b111;
      else        ack <= ack_stuck ? 3'b111 : clk_en;
   end

   function automatic logic [10:0] pack(input logic [1:0] st, input logic [2:0] en,
                                        input logic we, input logic [3:0] c, input logic ae);
      return {st, en, we, c, ae};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Advance to the next falling edge and score any commit that just happened
   task automatic tick();
      logic [10:0] exp_v;
      @(negedge clk);
      if (rst_n && ((state != prev_state) || (prev_busy && !busy))) begin
         check("sb_has_entry", 32'(sb.size() != 0), 32'(1));
         if (sb.size() != 0) begin
            exp_v = sb.pop_front();
            check("commit", 32'(pack(state, clk_en, wake_event, wake_cause, ack_err)), 32'(exp_v));
         end
      end
      if (rst_n && wake_event) n_wake_ev++;
      if (rst_n && ack_err)    n_ack_err++;
      prev_state = state;
      prev_busy  = busy;
   endtask

   task automatic req(input logic [1:0] s);
      req_if.i_req_valid = 1'b1;
      req_if.i_state_req = s;
      tick();
      req_if.i_req_valid = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      while ((busy || sb.size() != 0) && n < budget) begin
         tick();
         n++;
      end
      check("wait_idle_budget", 32'(n < budget), 32'(1));
   endtask

   initial begin
      int n;
      int ev0;
      int ae0;
      logic rdy_hi;

      rst_n = 1'b0;
      req_if.i_req_valid = 1'b0;
      req_if.i_state_req = 2'b00;
      auto_en = 1'b0;
      timeout = '0;
      activity = 1'b0;
      wake_src = '0;
      wake_mask = '0;
      ack_stuck = 1'b0;

      repeat (3) tick();
      check("rst_pack", 32'(pack(state, clk_en, wake_event, wake_cause, ack_err)),
            32'(pack(2'b00, 3'b111, 1'b0, 4'b0000, 1'b0)));
      check("rst_busy", 32'(busy), 32'(0));
      check("rst_ready", 32'(req_if.o_req_ready), 32'(1));
      rst_n = 1'b1;
      tick();

      // IDLE request, minimum handshake latency
      sb.push_back(pack(2'b01, 3'b001, 1'b0, 4'b0000, 1'b0));
      req(2'b01);
      check("idle_busy1", 32'({busy, req_if.o_req_ready, clk_en}), 32'({1'b1, 1'b0, 3'b001}));
      tick();
      check("idle_busy2", 32'(busy), 32'(1));
      tick();
      check("idle_done", 32'({busy, state}), 32'({1'b0, 2'b01}));

      // Activity wake from IDLE (cause 0); activity held to keep ACTIVE quiet
      sb.push_back(pack(2'b00, 3'b111, 1'b1, 4'b0000, 1'b0));
      activity = 1'b1;
      wait_idle(20);

      // Auto-idle: timeout 4 gives clk_en change 5 edges after activity drops
      timeout = 16'd4;
      auto_en = 1'b1;
      repeat (2) tick();
      sb.push_back(pack(2'b01, 3'b001, 1'b0, 4'b0000, 1'b0));
      activity = 1'b0;
      n = 0;
      while (clk_en != 3'b001 && n < 30) begin
         tick();
         n++;
      end
      check("auto_idle_lat", 32'(n), 32'(5));
      wait_idle(20);

      // Activity pulse at count 3 delays the auto-idle by 4 cycles
      sb.push_back(pack(2'b00, 3'b111, 1'b1, 4'b0000, 1'b0));
      activity = 1'b1;
      wait_idle(20);
      sb.push_back(pack(2'b01, 3'b001, 1'b0, 4'b0000, 1'b0));
      activity = 1'b0;
      n = 0;
      repeat (3) begin tick(); n++; end
      activity = 1'b1;
      tick();
      n++;
      activity = 1'b0;
      while (clk_en != 3'b001 && n < 30) begin
         tick();
         n++;
      end
      check("auto_idle_delay", 32'(n), 32'(9));
      wait_idle(20);
      auto_en = 1'b0;
      sb.push_back(pack(2'b00, 3'b111, 1'b0, 4'b0000, 1'b0));
      req(2'b00);
      wait_idle(20);

      // SLEEP, masked source ignored, enabled source wakes
      sb.push_back(pack(2'b10, 3'b000, 1'b0, 4'b0000, 1'b0));
      req(2'b10);
      wait_idle(20);
      wake_mask = 4'b0101;
      wake_src = 4'b0010;
      repeat (5) tick();
      check("masked_no_wake", 32'({busy, state}), 32'({1'b0, 2'b10}));
      ev0 = n_wake_ev;
      sb.push_back(pack(2'b00, 3'b111, 1'b1, 4'b0100, 1'b0));
      wake_src = 4'b0100;
      tick();
      check("wake_trans", 32'({busy, clk_en}), 32'({1'b1, 3'b111}));
      wake_src = 4'b0000;
      wait_idle(20);
      check("wake_pulses", 32'(n_wake_ev - ev0), 32'(1));

      // OFF with stuck acknowledge: forced commit after ACK_TO edges
      ack_stuck = 1'b1;
      ae0 = n_ack_err;
      sb.push_back(pack(2'b11, 3'b000, 1'b0, 4'b0100, 1'b1));
      req(2'b11);
      n = 0;
      while (busy && n < 200) begin
         tick();
         n++;
      end
      check("ack_to_lat", 32'(n), 32'(64));
      check("ack_err_pulses", 32'(n_ack_err - ae0), 32'(1));
      ack_stuck = 1'b0;
      sb.push_back(pack(2'b00, 3'b111, 1'b0, 4'b0100, 1'b0));
      req(2'b00);
      wait_idle(20);

      // Wake during TRANS toward SLEEP: commit SLEEP then return to ACTIVE
      ev0 = n_wake_ev;
      sb.push_back(pack(2'b10, 3'b111, 1'b0, 4'b0001, 1'b0));
      sb.push_back(pack(2'b00, 3'b111, 1'b1, 4'b0001, 1'b0));
      req(2'b10);
      wake_src = 4'b0001;
      rdy_hi = req_if.o_req_ready;
      n = 0;
      while ((busy || sb.size() != 0) && n < 30) begin
         tick();
         n++;
         if (busy) rdy_hi = rdy_hi | req_if.o_req_ready;
      end
      check("pend_budget", 32'(n < 30), 32'(1));
      check("pend_ready_low", 32'(rdy_hi), 32'(0));
      check("pend_wake_pulses", 32'(n_wake_ev - ev0), 32'(1));
      wake_src = 4'b0000;
      tick();

      // Asynchronous reset in the middle of a transition
      ack_stuck = 1'b1;
      req(2'b11);
      check("pre_rst_busy", 32'({busy, clk_en}), 32'({1'b1, 3'b000}));
      #2 rst_n = 1'b0;
      #1;
      check("rst_mid", 32'({clk_en, state, busy, req_if.o_req_ready, wake_cause}),
            32'({3'b111, 2'b00, 1'b0, 1'b1, 4'b0000}));
      tick();
      rst_n = 1'b1;
      ack_stuck = 1'b0;
      tick();

      check("sb_empty", 32'(sb.size()), 32'(0));
      $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
      $finish;
   end

endmodule
